mod_sekuencial: RTL and testbench

Multi-cycle unsigned 16-bit modulo unit that produces the MOD result consumed by the CPU's ALU result multiplexer (select code 3'b111).
- It is the producer end of that path: the control unit issues a start pulse with the operands, the unit computes `Hyrja0 % Hyrja1` by restoring shift-subtract, and it returns the remainder with a one-cycle done strobe.
- The control unit holds the pipeline while `Busy` is high.

---
 rtl/mod_sekuencial.sv | 127 ++++++++++++
 tb/tb_mod_sekuencial.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mod_sekuencial.sv
`default_nettype none
// ============================================================================
// Module   : mod_sekuencial
// Purpose  : Multi-cycle unsigned modulo unit (Hyrja0 % Hyrja1) using
//            restoring shift-subtract, one quotient bit per cycle. It feeds
//            the MOD input of the ALU result multiplexer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock   in   1  rising-edge clock
//   Reset   in   1  synchronous, active-high; aborts any operation silently
//   Start   in   1  request strobe, accepted only while idle
//   Hyrja0  in   W  dividend, captured on an accepted Start
//   Hyrja1  in   W  divisor, captured on an accepted Start
//   Dalja   out  W  remainder, registered, held until the next completion
//   Busy    out  1  high whenever the unit is not idle
//   Gati    out  1  one-cycle done strobe, Dalja is new while it is high
//   DivZero out  1  high with Gati when the captured divisor was zero
// ============================================================================
module mod_sekuencial #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Hyrja0,
  input  logic [W-1:0] Hyrja1,
  output logic [W-1:0] Dalja,
  output logic         Busy,
  output logic         Gati,
  output logic         DivZero
);

  localparam int NW = $clog2(W) + 1;
  localparam logic [NW-1:0] N_LAST = NW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LLOGARIT = 2'd1,
    S_GATI     = 2'd2
  } state_t;

  state_t        state_q;
  logic [W:0]    r_q;      // partial remainder, MSB only matters for compare
  logic [W:0]    r_d;
  logic [W-1:0]  q_q;      // dividend shift register, MSB first
  logic [W-1:0]  d_q;      // captured divisor
  logic [NW-1:0] n_q;      // iteration counter

  logic [W:0]    t_w;
  logic [W:0]    dext_w;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    t_w    = {r_q[W-1:0], q_q[W-1]};
    dext_w = {1'b0, d_q};
    r_d    = t_w;
    if (t_w >= dext_w) begin
      r_d = t_w - dext_w;
    end
  end

  // The remainder is always below the divisor, so R's MSB never reaches
  // the output; it is kept only so the stored width matches the compare.
  logic unused_rmsb;
  assign unused_rmsb = r_q[W];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      Dalja   <= '0;
      Gati    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            q_q <= Hyrja0;
            d_q <= Hyrja1;
            r_q <= '0;
            n_q <= '0;
            if (Hyrja1 != '0) begin
              state_q <= S_LLOGARIT;
            end else begin
              // Divide-by-zero short-circuits straight to completion,
              // returning the dividend unchanged.
              state_q <= S_GATI;
              Dalja   <= Hyrja0;
              Gati    <= 1'b1;
              DivZero <= 1'b1;
            end
          end
        end

        S_LLOGARIT: begin
          q_q <= q_q << 1;
          r_q <= r_d;
          n_q <= n_q + 1'b1;
          if (n_q == N_LAST) begin
            // Result is captured from the final step so it is valid in GATI.
            state_q <= S_GATI;
            Dalja   <= r_d[W-1:0];
            Gati    <= 1'b1;
          end
        end

        S_GATI: begin
          Gati    <= 1'b0;
          DivZero <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_sekuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_sekuencial
// Purpose  : Directed self-checking bench for mod_sekuencial.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_sekuencial;

  localparam int W = 16;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic [W-1:0] Hyrja0;
  logic [W-1:0] Hyrja1;
  logic [W-1:0] Dalja;
  logic         Busy;
  logic         Gati;
  logic         DivZero;

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] prev_rem;

  mod_sekuencial #(.W(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Hyrja0  (Hyrja0),
    .Hyrja1  (Hyrja1),
    .Dalja   (Dalja),
    .Busy    (Busy),
    .Gati    (Gati),
    .DivZero (DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Non-zero divisor op started in the current (idle) cycle; returns in
  // cycle 18, idle, ready for another Start.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_rem);
    Start = 1'b1; Hyrja0 = a; Hyrja1 = b;
    tick();
    Start = 1'b0; Hyrja0 = $urandom; Hyrja1 = $urandom;
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("busy c%0d", c), Busy, 1'b1);
      chk($sformatf("gati c%0d", c), Gati, (c == 17));
      chk($sformatf("dz c%0d", c), DivZero, 1'b0);
      if (c < 17) chk($sformatf("hold c%0d", c), Dalja, prev_rem);
      else        chk($sformatf("rem %0d%%%0d", a, b), Dalja, exp_rem);
      tick();
    end
    chk("busy c18", Busy, 1'b0);
    chk("gati c18", Gati, 1'b0);
    chk("hold c18", Dalja, exp_rem);
    prev_rem = exp_rem;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Hyrja0 = '0; Hyrja1 = '0;
    tick(); tick();
    chk("rst dalja", Dalja, 16'h0);
    chk("rst busy", Busy, 1'b0);
    chk("rst gati", Gati, 1'b0);
    chk("rst dz", DivZero, 1'b0);
    Reset = 1'b0;
    prev_rem = '0;
    tick();

    // Basic and extremes
    run_op(16'd100, 16'd7, 16'd2);
    run_op(16'hFFFF, 16'h0001, 16'h0000);
    run_op(16'hFFFF, 16'hFFFF, 16'h0000);
    run_op(16'd3, 16'd10, 16'd3);
    run_op(16'h8000, 16'h00FF, 16'h0080);

    // Divide by zero
    Start = 1'b1; Hyrja0 = 16'd5; Hyrja1 = 16'd0;
    tick();
    Start = 1'b0;
    chk("dz busy c1", Busy, 1'b1);
    chk("dz gati c1", Gati, 1'b1);
    chk("dz flag c1", DivZero, 1'b1);
    chk("dz rem c1", Dalja, 16'd5);
    tick();
    chk("dz busy c2", Busy, 1'b0);
    chk("dz gati c2", Gati, 1'b0);
    chk("dz flag c2", DivZero, 1'b0);
    chk("dz hold c2", Dalja, 16'd5);
    prev_rem = 16'd5;
    run_op(16'd9, 16'd4, 16'd1);

    // Start during computation is ignored
    Start = 1'b1; Hyrja0 = 16'd100; Hyrja1 = 16'd7;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 5) begin Start = 1'b1; Hyrja0 = 16'd50; Hyrja1 = 16'd3; end
      if (c == 6) Start = 1'b0;
      chk($sformatf("ign gati c%0d", c), Gati, (c == 17));
      if (c == 17) chk("ign rem", Dalja, 16'd2);
      tick();
    end
    prev_rem = 16'd2;

    // Reset mid-operation
    Start = 1'b1; Hyrja0 = 16'd1000; Hyrja1 = 16'd7;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid rst dalja", Dalja, 16'h0);
    chk("mid rst busy", Busy, 1'b0);
    chk("mid rst gati", Gati, 1'b0);
    chk("mid rst dz", DivZero, 1'b0);
    for (int c = 10; c <= 30; c++) begin
      chk($sformatf("abort gati c%0d", c), Gati, 1'b0);
      tick();
    end
    prev_rem = '0;
    run_op(16'd1000, 16'd7, 16'd6);

    // Back-to-back: second Start lands exactly in cycle 18
    run_op(16'd100, 16'd7, 16'd2);
    run_op(16'd12345, 16'd100, 16'd45);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
